// File: rtl/uart_rx_core.sv
// UART receiver: 8 data bits LSB first, optional even parity, one stop bit.
// Mid-bit sampling from a latched divisor; one-deep output register with valid/ready.
module uart_rx_core #(
  parameter bit          PARITY_EN = 1'b1,
  parameter int unsigned DIV_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] divisor,
  input  logic             rx,
  output logic [7:0]       data,
  output logic             valid,
  input  logic             ready,
  output logic             parity_error,
  output logic             framing_error,
  output logic             overflow,
  output logic             busy
);

  localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q;
  logic [1:0]       fill_q;
  logic             rxs_prev_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             ovf_q, ovf_d;

  logic             rxs;
  logic             fall;
  logic             tick;
  logic [DIV_W-1:0] div_half;
  logic [DIV_W-1:0] reload;

  assign rxs      = sync_q[1];
  assign fall     = rxs_prev_q & ~rxs;
  assign tick     = (cnt_q == '0);
  assign div_half = divisor >> 1;
  assign reload   = div_q - DivOne;

  // fill_q marks when the synchronizer holds real line samples rather than its
  // reset value, so a line held low across reset release is not seen as a start.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= 2'b11;
      fill_q     <= 2'b00;
      rxs_prev_q <= 1'b0;
      state_q    <= StIdle;
      div_q      <= '0;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      fill_q     <= {fill_q[0], 1'b1};
      rxs_prev_q <= fill_q[1] & sync_q[1];
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_d    = data_q;
    valid_d   = valid_q & ~ready;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    ovf_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d = StStart;
          div_d   = divisor;
          cnt_d   = div_half - DivOne;
        end
      end

      StStart: begin
        if (tick) begin
          cnt_d     = reload;
          bit_idx_d = '0;
          state_d   = rxs ? StIdle : StData;
        end else begin
          cnt_d = cnt_q - DivOne;
        end
      end

      StData: begin
        if (tick) begin
          cnt_d     = reload;
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = PARITY_EN ? StParity : StStop;
          end
        end else begin
          cnt_d = cnt_q - DivOne;
        end
      end

      StParity: begin
        if (tick) begin
          cnt_d   = reload;
          par_d   = rxs;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q - DivOne;
        end
      end

      StStop: begin
        if (tick) begin
          // Classification is registered here so results appear one cycle
          // after the stop sample; priority gives at most one pulse per frame.
          if (!rxs) begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end else begin
            state_d = StIdle;
            if (PARITY_EN && (par_q != ^shift_q)) begin
              perr_d = 1'b1;
            end else if (valid_q && !ready) begin
              ovf_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - DivOne;
        end
      end

      StBreak: begin
        if (rxs) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign overflow      = ovf_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frame timing, error classification,
// overflow, glitch rejection and mid-frame reset.
module tb_uart_rx_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] divisor;
  logic        rx;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        parity_error;
  logic        framing_error;
  logic        overflow;
  logic        busy;

  uart_rx_core dut (
    .clk          (clk),
    .reset        (reset),
    .divisor      (divisor),
    .rx           (rx),
    .data         (data),
    .valid        (valid),
    .ready        (ready),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampled on the falling edge, away from the active edge.
  int         vrise_cnt = 0, vrise_cyc = 0, vhigh_cnt = 0;
  int         pe_cnt = 0, fe_cnt = 0, ov_cnt = 0, ov_cyc = 0, busy_cnt = 0, dchg_cnt = 0;
  logic [7:0] vrise_data = 8'h00, data_prev = 8'h00;
  logic       valid_prev = 1'b0, ready_prev = 1'b0;

  always @(negedge clk) begin
    if (valid && !valid_prev) begin
      vrise_cnt  = vrise_cnt + 1;
      vrise_cyc  = cyc;
      vrise_data = data;
    end
    if (valid) vhigh_cnt = vhigh_cnt + 1;
    if (parity_error) pe_cnt = pe_cnt + 1;
    if (framing_error) fe_cnt = fe_cnt + 1;
    if (overflow) begin
      ov_cnt = ov_cnt + 1;
      ov_cyc = cyc;
    end
    if (busy) busy_cnt = busy_cnt + 1;
    if (valid_prev && valid && !ready_prev && data != data_prev) dchg_cnt = dchg_cnt + 1;
    valid_prev = valid;
    data_prev  = data;
    ready_prev = ready;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (got === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int div);
    rx = b;
    tick(div);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int div, output int k);
    k = cyc;
    drive_bit(1'b0, div);
    for (int i = 0; i < 8; i++) drive_bit(d[i], div);
    drive_bit(par, div);
    drive_bit(stop, div);
  endtask

  int k, k2, lo_cnt;
  int b_vr, b_vh, b_pe, b_fe, b_ov, b_busy, b_dc;

  task automatic snap();
    b_vr   = vrise_cnt;
    b_vh   = vhigh_cnt;
    b_pe   = pe_cnt;
    b_fe   = fe_cnt;
    b_ov   = ov_cnt;
    b_busy = busy_cnt;
    b_dc   = dchg_cnt;
  endtask

  initial begin
    reset   = 1'b1;
    rx      = 1'b1;
    ready   = 1'b1;
    divisor = 16'd4;
    tick(3);

    // Reset state, and outputs frozen while reset is held whatever rx does.
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_perr", 32'(parity_error), 32'h0);
    check("rst_ferr", 32'(framing_error), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(1);
    rx = 1'b0;
    tick(2);
    check("rst_hold_busy", 32'(busy), 32'h0);
    check("rst_hold_valid", 32'(valid), 32'h0);
    check("rst_hold_errs", 32'({parity_error, framing_error, overflow}), 32'h0);
    rx = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(6);

    // Good frame 0xA5, divisor 4: valid one cycle after the stop sample (T0 = k+2).
    snap();
    send_frame(8'hA5, 1'b0, 1'b1, 4, k);
    tick(4);
    check("a5_rise_cyc", vrise_cyc, k + 45);
    check("a5_data", 32'(vrise_data), 32'hA5);
    check("a5_rises", vrise_cnt - b_vr, 1);
    check("a5_valid_cycles", vhigh_cnt - b_vh, 1);
    check("a5_pulses", (pe_cnt - b_pe) + (fe_cnt - b_fe) + (ov_cnt - b_ov), 0);
    check("a5_valid_now", 32'(valid), 32'h0);

    // Bad parity on 0x01 is dropped, then 0x02 with correct parity lands.
    snap();
    send_frame(8'h01, 1'b0, 1'b1, 4, k);
    tick(4);
    check("p01_perr", pe_cnt - b_pe, 1);
    check("p01_no_valid", vrise_cnt - b_vr, 0);
    send_frame(8'h02, 1'b1, 1'b1, 4, k);
    tick(4);
    check("p02_rises", vrise_cnt - b_vr, 1);
    check("p02_data", 32'(vrise_data), 32'h02);
    check("p02_other", (fe_cnt - b_fe) + (ov_cnt - b_ov), 0);

    // Framing error on 0x3C followed by a long break.
    snap();
    send_frame(8'h3C, 1'b0, 1'b0, 4, k);
    lo_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (!busy) lo_cnt = lo_cnt + 1;
    end
    check("brk_busy_low_cycles", lo_cnt, 0);
    check("brk_ferr", fe_cnt - b_fe, 1);
    check("brk_other", (pe_cnt - b_pe) + (ov_cnt - b_ov) + (vrise_cnt - b_vr), 0);
    rx = 1'b1;
    tick(2);
    check("brk_busy_still", 32'(busy), 32'h1);
    tick(1);
    check("brk_busy_clear", 32'(busy), 32'h0);
    tick(4);
    check("brk_ferr_total", fe_cnt - b_fe, 1);

    // Overflow: ready low, 0x11 then 0x22 back to back.
    ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b0, 1'b1, 4, k);
    send_frame(8'h22, 1'b0, 1'b1, 4, k2);
    tick(4);
    check("ovf_rises", vrise_cnt - b_vr, 1);
    check("ovf_data", 32'(data), 32'h11);
    check("ovf_valid", 32'(valid), 32'h1);
    check("ovf_pulses", ov_cnt - b_ov, 1);
    check("ovf_cyc", ov_cyc, k2 + 45);
    check("ovf_data_stable", dchg_cnt - b_dc, 0);
    ready = 1'b1;
    tick(1);
    check("ovf_consumed_valid", 32'(valid), 32'h0);
    check("ovf_consumed_data", 32'(data), 32'h11);

    // One-cycle glitch with divisor 8: START holds for floor(8/2) cycles then aborts.
    divisor = 16'd8;
    tick(2);
    snap();
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(20);
    check("gl_busy_cycles", busy_cnt - b_busy, 4);
    check("gl_pulses", (pe_cnt - b_pe) + (fe_cnt - b_fe) + (ov_cnt - b_ov), 0);
    check("gl_no_valid", vrise_cnt - b_vr, 0);
    check("gl_valid", 32'(valid), 32'h0);

    // Frame 0xC3 at divisor 8.
    send_frame(8'hC3, 1'b0, 1'b1, 8, k);
    tick(4);
    check("d8_rise_cyc", vrise_cyc, k + 87);
    check("d8_data", 32'(vrise_data), 32'hC3);

    // Reset during data bit 4 of 0x66, line left low across release.
    divisor = 16'd4;
    tick(2);
    k = cyc;
    drive_bit(1'b0, 4);
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 4);
    drive_bit(1'b1, 4);
    drive_bit(1'b0, 4);
    rx = 1'b0;
    tick(2);
    check("mid_busy_before", 32'(busy), 32'h1);
    reset = 1'b1;
    tick(1);
    snap();
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_data", 32'(data), 32'h00);
    check("mid_rst_valid", 32'(valid), 32'h0);
    tick(2);
    reset = 1'b0;
    tick(8);
    rx = 1'b1;
    tick(4);
    check("mid_no_start", busy_cnt - b_busy, 0);
    check("mid_no_pulses", (pe_cnt - b_pe) + (fe_cnt - b_fe) + (ov_cnt - b_ov), 0);
    send_frame(8'h5A, 1'b0, 1'b1, 4, k);
    tick(4);
    check("mid_5a_rise_cyc", vrise_cyc, k + 45);
    check("mid_5a_data", 32'(vrise_data), 32'h5A);
    check("mid_5a_rises", vrise_cnt - b_vr, 1);
    check("mid_5a_pulses", (pe_cnt - b_pe) + (fe_cnt - b_fe) + (ov_cnt - b_ov), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
